// File: rtl/phys_reg_free_list_pkg.sv
// Shared rename-bus sizing: physical/architectural register counts and the
// physical register number width used by the free list and the rename datapath.
package phys_reg_free_list_pkg;

  localparam int PREG_NUM = 128;
  localparam int ARCH_NUM = 32;
  localparam int PREG_W   = 7;

endpackage

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register numbers: up to two allocations to
// rename and two releases from ROB commit per cycle, single-cycle reinit on flash.
module phys_reg_free_list #(
  parameter int PREG_NUM = phys_reg_free_list_pkg::PREG_NUM,
  parameter int ARCH_NUM = phys_reg_free_list_pkg::ARCH_NUM,
  parameter int PREG_W   = phys_reg_free_list_pkg::PREG_W
) (
  input  logic              Clk,
  input  logic              Rest,
  input  logic              FreeListStop,
  input  logic              FreeListFlash,
  input  logic              AllocReq1,
  input  logic              AllocReq2,
  output logic              AllocGrant,
  output logic [PREG_W-1:0] AllocPreg1,
  output logic [PREG_W-1:0] AllocPreg2,
  input  logic              Release1,
  input  logic [PREG_W-1:0] Release1Preg,
  input  logic              Release2,
  input  logic [PREG_W-1:0] Release2Preg,
  output logic [PREG_W:0]   FreeCount,
  output logic              FreeListEmpty
);

  localparam int CNT_W     = PREG_W + 1;
  localparam int INIT_FREE = PREG_NUM - ARCH_NUM;

  logic [PREG_W-1:0] entry_q [PREG_NUM];
  logic [PREG_W-1:0] head_q, head_d;
  logic [PREG_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [1:0]        need;
  logic [CNT_W-1:0]  need_w;
  logic [CNT_W-1:0]  granted;
  logic [CNT_W-1:0]  released;
  logic              grant;
  logic              accept1;
  logic              accept2;
  logic [PREG_W-1:0] wr2_idx;

  // Pregs ARCH_NUM.. are free after init; the first ARCH_NUM hold committed state.
  function automatic logic [PREG_W-1:0] init_entry(input int idx);
    return (idx < INIT_FREE) ? PREG_W'(idx + ARCH_NUM) : '0;
  endfunction

  always_comb begin
    need     = {1'b0, AllocReq1} + {1'b0, AllocReq2};
    need_w   = CNT_W'(need);
    grant    = !FreeListStop && !FreeListFlash && (need != 2'd0) && (count_q >= need_w);
    granted  = grant ? need_w : '0;
    // Grant looks only at the registered count; releases never bypass into alloc.
    // Releases that would push the count past PREG_NUM are dropped.
    accept1  = Release1 && (count_q < CNT_W'(PREG_NUM));
    accept2  = Release2 && ((count_q + CNT_W'(accept1)) < CNT_W'(PREG_NUM));
    released = CNT_W'(accept1) + CNT_W'(accept2);
    wr2_idx  = tail_q + PREG_W'(accept1);
    head_d   = head_q + PREG_W'(granted);
    tail_d   = tail_q + PREG_W'(released);
    count_d  = count_q - granted + released;
  end

  assign AllocGrant    = grant;
  assign AllocPreg1    = entry_q[head_q];
  assign AllocPreg2    = AllocReq1 ? entry_q[head_q + PREG_W'(1)] : entry_q[head_q];
  assign FreeCount     = count_q;
  assign FreeListEmpty = count_q < CNT_W'(2);

  // NOTE: the storage array is reset on purpose -- reset and flash must both
  // restore a known list contents, so it is built from flops, not a RAM macro.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      head_q  <= '0;
      tail_q  <= PREG_W'(INIT_FREE);
      count_q <= CNT_W'(INIT_FREE);
      for (int i = 0; i < PREG_NUM; i++) entry_q[i] <= init_entry(i);
    end else if (FreeListFlash) begin
      head_q  <= '0;
      tail_q  <= PREG_W'(INIT_FREE);
      count_q <= CNT_W'(INIT_FREE);
      for (int i = 0; i < PREG_NUM; i++) entry_q[i] <= init_entry(i);
    end else if (!FreeListStop) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (accept1) entry_q[tail_q]  <= Release1Preg;
      if (accept2) entry_q[wr2_idx] <= Release2Preg;
    end
  end

endmodule
